affine_param_sequencer: RTL
===========================

Name: affine_param_sequencer

Overview:
- Parameter-side controller for the ViT affine layernorm datapath.
- Holds one row's worth of per-channel affine parameters: NUM_TILES vectors of IN_SIZE weights and biases.
- Replays them tile by tile on independent weight and bias valid/ready channels, wrapping every row. One parameter load is reused for all tokens.
- Supports a row-aligned reload of a new parameter set.

Parameters:
- IN_WIDTH, 32, weight element width (matches datapath data/weight width)
- BIAS_WIDTH, 8, bias element width
- IN_SIZE, 4, elements per vector beat
- NUM_TILES, 4, beats per normalized row (hidden_dim / IN_SIZE); must be >= 1
- PTR_WIDTH, max(1,$clog2(NUM_TILES)), tile pointer width (derived localparam)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- param_weight_in  in  IN_WIDTH x IN_SIZE  weight beat being loaded
- param_bias_in  in  BIAS_WIDTH x IN_SIZE  bias beat being loaded
- param_in_valid  in  1  load beat valid
- param_in_ready  out  1  load beat accepted when valid&&ready
- reload  in  1  single-cycle request to replace the parameter set
- weight  out  IN_WIDTH x IN_SIZE  weight vector for current weight tile
- weight_valid  out  1
- weight_ready  in  1
- bias  out  BIAS_WIDTH x IN_SIZE  bias vector for current bias tile
- bias_valid  out  1
- bias_ready  in  1
- loaded  out  1  high in RUN
- weight_tile_idx  out  PTR_WIDTH  current weight pointer
- bias_tile_idx  out  PTR_WIDTH  current bias pointer

Behaviour:
- Storage: two register arrays [NUM_TILES] (weight, bias). Outputs are a combinational read at the respective pointer; no read latency.
- FSM states LOAD, RUN, DRAIN. All state, pointers and flags are registered.
- Reset (rst=1 at a clock edge):
  - state=LOAD; load_ptr=w_ptr=b_ptr=0; reload_pending=0.
  - Outputs: weight_valid=bias_valid=0, loaded=0.
  - param_in_ready=1 from the first cycle after rst deasserts.
  - Storage contents are not reset.
  - Reset mid-load or mid-run discards progress; a full reload is required.
- LOAD:
  - param_in_ready=1; weight_valid=bias_valid=0.
  - Each accepted beat writes entry load_ptr, then load_ptr++.
  - Beat NUM_TILES-1 accepted -> RUN next cycle with load_ptr=0, w_ptr=b_ptr=0.
  - reload during LOAD is ignored.
- RUN:
  - weight_valid=bias_valid=1; param_in_ready=0.
  - weight_valid&&weight_ready advances w_ptr, wrapping NUM_TILES-1 -> 0. b_ptr advances on bias_valid&&bias_ready, same wrap.
  - The channels are independent; skew between pointers is allowed (the weight path feeds a multiplier stage ahead of the bias join).
- reload in RUN:
  - Sets reload_pending. If w_ptr==0 and b_ptr==0 with no handshake that cycle, go directly to LOAD next cycle.
  - Otherwise go to DRAIN.
- DRAIN:
  - Each channel keeps serving until its pointer wraps to 0, then holds valid=0.
  - When both pointers are 0 -> LOAD; reload_pending clears.
  - Further reload pulses in DRAIN are absorbed.
- Simultaneous reload and the wrapping handshake of the last tile in RUN: the handshake completes, the pointer wraps to 0, and that channel stops.
- NUM_TILES=1: pointers stay 0; every handshake is a wrap.
- A valid output never drops without a handshake, except on rst.

Optional Feature:
- Macro AFFINE_SEQ_ROW_COUNT_EN.
- Defined:
  - Adds output rows_served [15:0].
  - Increments, saturating at 16'hFFFF, each time b_ptr wraps NUM_TILES-1 -> 0.
  - Clears on rst and on entry to LOAD.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package affine_seq_pkg:
  - state enum (LOAD, RUN, DRAIN)
  - PTR_WIDTH computation function
- One natural sub-module, affine_tile_ptr: a wrapping tile counter with advance input, wrap-flag output and hold-at-zero enable. Instantiated twice (weight, bias).

Test Plan:
- Reset then load 4 beats (weights 1..4 replicated, biases 10..40) -> loaded rises the cycle after the 4th accept; weight=1, bias=10, both valids=1.
- Weight_ready=1 constant, bias_ready=0 for 6 cycles -> w_ptr sequence 1,2,3,0,1,2; bias holds tile 0 with valid=1.
- Reload at w_ptr=2, b_ptr=1 -> DRAIN. Weight serves tiles 2,3 then valid=0; bias serves tiles 1,2,3 then valid=0; LOAD on the following cycle, param_in_ready=1.
- Reload with both pointers 0 and no handshake -> LOAD next cycle; no tile is emitted.
- rst asserted after 2 of 4 load beats -> the next load requires 4 full beats; loaded stays 0 until then.
- With AFFINE_SEQ_ROW_COUNT_EN: 3 full bias rows (12 handshakes) -> rows_served=3; reload -> 0 on entry to LOAD.

Source files
------------

// File: rtl/affine_seq_pkg.sv
// Shared types and helpers for the affine parameter sequencer.
// Holds the controller state encoding and tile pointer width function.
package affine_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/affine_tile_ptr.sv
// Wrapping tile pointer with advance, wrap flag and hold-at-zero.
// One instance per output channel of the affine parameter sequencer.
module affine_tile_ptr #(
    parameter int NUM_TILES = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 adv_i,
    input  logic                 hold_zero_i,
    output logic [PTR_WIDTH-1:0] ptr_o,
    output logic                 wrap_o
);

    localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(NUM_TILES - 1);

    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic                 adv_eff;

    // A drained channel parks at tile 0 and ignores further advances
    assign adv_eff = adv_i && !(hold_zero_i && (ptr_q == '0));
    assign wrap_o  = adv_eff && (ptr_q == LAST);
    assign ptr_o   = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (adv_eff) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/affine_param_sequencer.sv
// Stores one row of affine weights/biases and replays them per tile.
// Optional AFFINE_SEQ_ROW_COUNT_EN adds a saturating rows_served counter.
module affine_param_sequencer
    import affine_seq_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int BIAS_WIDTH = 8,
    parameter int IN_SIZE    = 4,
    parameter int NUM_TILES  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IN_WIDTH*IN_SIZE-1:0]         param_weight_in,
    input  logic [BIAS_WIDTH*IN_SIZE-1:0]       param_bias_in,
    input  logic                                param_in_valid,
    output logic                                param_in_ready,
    input  logic                                reload,
    output logic [IN_WIDTH*IN_SIZE-1:0]         weight,
    output logic                                weight_valid,
    input  logic                                weight_ready,
    output logic [BIAS_WIDTH*IN_SIZE-1:0]       bias,
    output logic                                bias_valid,
    input  logic                                bias_ready,
    output logic                                loaded,
    output logic [ptr_width(NUM_TILES)-1:0]     weight_tile_idx,
    output logic [ptr_width(NUM_TILES)-1:0]     bias_tile_idx
`ifdef AFFINE_SEQ_ROW_COUNT_EN
    ,
    output logic [15:0]                         rows_served
`endif
);

    localparam int PTR_WIDTH = ptr_width(NUM_TILES);
    localparam int WW        = IN_WIDTH * IN_SIZE;
    localparam int BW        = BIAS_WIDTH * IN_SIZE;
    localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(NUM_TILES - 1);

    state_e               state_q, state_d;
    logic [PTR_WIDTH-1:0] load_ptr_q, load_ptr_d;
    logic                 reload_pending_q, reload_pending_d;

    logic [WW-1:0] w_mem_q [NUM_TILES];
    logic [BW-1:0] b_mem_q [NUM_TILES];

    logic                 load_acc;
    logic                 w_hs, b_hs;
    logic                 w_wrap, b_wrap;
    logic                 ptr_clr, drain;
    logic [PTR_WIDTH-1:0] w_ptr, b_ptr;

    assign load_acc = param_in_valid && param_in_ready;
    assign w_hs     = weight_valid && weight_ready;
    assign b_hs     = bias_valid && bias_ready;
    assign ptr_clr  = (state_q == ST_LOAD);
    assign drain    = (state_q == ST_DRAIN);

    affine_tile_ptr #(
        .NUM_TILES (NUM_TILES),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_w_ptr (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (ptr_clr),
        .adv_i       (w_hs),
        .hold_zero_i (drain),
        .ptr_o       (w_ptr),
        .wrap_o      (w_wrap)
    );

    affine_tile_ptr #(
        .NUM_TILES (NUM_TILES),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_b_ptr (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (ptr_clr),
        .adv_i       (b_hs),
        .hold_zero_i (drain),
        .ptr_o       (b_ptr),
        .wrap_o      (b_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_LOAD;
            load_ptr_q       <= '0;
            reload_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            load_ptr_q       <= load_ptr_d;
            reload_pending_q <= reload_pending_d;
        end
    end

    // Parameter storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (load_acc) begin
            w_mem_q[load_ptr_q] <= param_weight_in;
            b_mem_q[load_ptr_q] <= param_bias_in;
        end
    end

    always_comb begin
        state_d          = state_q;
        load_ptr_d       = load_ptr_q;
        reload_pending_d = reload_pending_q;
        unique case (state_q)
            ST_LOAD: begin
                reload_pending_d = 1'b0;
                if (load_acc) begin
                    if (load_ptr_q == LAST) begin
                        load_ptr_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        load_ptr_d = load_ptr_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (reload) begin
                    if ((w_ptr == '0) && (b_ptr == '0) && !w_hs && !b_hs) begin
                        state_d = ST_LOAD;
                    end else begin
                        reload_pending_d = 1'b1;
                        state_d          = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (reload_pending_q && (w_ptr == '0) && (b_ptr == '0)) begin
                    reload_pending_d = 1'b0;
                    state_d          = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // While draining, a channel stays valid only until it has wrapped
    always_comb begin
        param_in_ready = (state_q == ST_LOAD) && !rst;
        loaded         = (state_q == ST_RUN);
        weight_valid   = (state_q == ST_RUN) || (drain && (w_ptr != '0));
        bias_valid     = (state_q == ST_RUN) || (drain && (b_ptr != '0));
    end

    assign weight          = w_mem_q[w_ptr];
    assign bias            = b_mem_q[b_ptr];
    assign weight_tile_idx = w_ptr;
    assign bias_tile_idx   = b_ptr;

`ifdef AFFINE_SEQ_ROW_COUNT_EN
    logic [15:0] rows_q, rows_d;
    logic        unused_wrap;

    assign unused_wrap = w_wrap;

    always_comb begin
        rows_d = rows_q;
        if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            rows_d = '0;
        end else if (b_wrap && (rows_q != 16'hFFFF)) begin
            rows_d = rows_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q <= '0;
        end else begin
            rows_q <= rows_d;
        end
    end

    assign rows_served = rows_q;
`else
    logic unused_wrap;

    assign unused_wrap = w_wrap ^ b_wrap;
`endif

endmodule
